// File: rtl/operand_gather_if.sv
// Handshake and operand bus between the word source, operand_gather and the
// 8-input reduction stage.
interface operand_gather_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] e;
  logic [WIDTH-1:0] f;
  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] h;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       word_cnt;

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, a, b, c, d, e, f, g, h, out_valid, word_cnt
  );

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, a, b, c, d, e, f, g, h, out_valid, word_cnt
  );
endinterface

// File: rtl/operand_gather.sv
// Serial-to-parallel collector: packs up to eight words into operand slots a..h,
// padding a short group with the reduction-neutral value.
module operand_gather #(
  parameter int WIDTH    = 8,
  parameter bit PAD_ONES = 1'b1
) (
  input  logic             clk,
  input  logic             resetn,
  operand_gather_if.slave  bus
);

  localparam logic [WIDTH-1:0] PAD = {WIDTH{PAD_ONES}};

  typedef enum logic [0:0] {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e           state_q;
  state_e           state_d;
  logic [WIDTH-1:0] slot_q [8];
  logic [WIDTH-1:0] slot_d [8];
  logic [3:0]       cnt_q;
  logic [3:0]       cnt_d;
  logic             accept_s;
  logic             done_s;
  logic             release_s;

  assign accept_s  = bus.in_valid && (state_q == FILL);
  assign done_s    = accept_s && ((cnt_q == 4'd7) || bus.in_last);
  assign release_s = bus.out_ready && (state_q == HOLD);

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL: begin
        if (done_s) begin
          state_d = HOLD;
        end else begin
          state_d = FILL;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_d = FILL;
        end else begin
          state_d = HOLD;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // Handshake outputs decoded from registered state only
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state_q)
      FILL:    bus.in_ready  = 1'b1;
      HOLD:    bus.out_valid = 1'b1;
      default: bus.in_ready  = 1'b0;
    endcase
  end

  // Slot and count next-state: write the addressed slot, pad the tail on in_last
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < 8; i++) begin
      slot_d[i] = slot_q[i];
    end
    if (accept_s) begin
      cnt_d = cnt_q + 4'd1;
      for (int i = 0; i < 8; i++) begin
        if (4'(i) == cnt_q) begin
          slot_d[i] = bus.in_data;
        end else if ((4'(i) > cnt_q) && bus.in_last) begin
          slot_d[i] = PAD;
        end else begin
          slot_d[i] = slot_q[i];
        end
      end
    end else if (release_s) begin
      cnt_d = 4'd0;
      for (int i = 0; i < 8; i++) begin
        slot_d[i] = PAD;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Slot and count registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q <= 4'd0;
      for (int i = 0; i < 8; i++) begin
        slot_q[i] <= PAD;
      end
    end else begin
      cnt_q <= cnt_d;
      for (int i = 0; i < 8; i++) begin
        slot_q[i] <= slot_d[i];
      end
    end
  end

  assign bus.a        = slot_q[0];
  assign bus.b        = slot_q[1];
  assign bus.c        = slot_q[2];
  assign bus.d        = slot_q[3];
  assign bus.e        = slot_q[4];
  assign bus.f        = slot_q[5];
  assign bus.g        = slot_q[6];
  assign bus.h        = slot_q[7];
  assign bus.word_cnt = cnt_q;

endmodule

// File: tb/tb_operand_gather.sv
// Bench for operand_gather: two instances (all-ones and all-zeros padding) share
// one stimulus stream and are compared every cycle against a queue-based model.
module tb_operand_gather;

  localparam int W = 7;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic [W-1:0] drv_data = '0;
  logic         drv_valid = 1'b0;
  logic         drv_last = 1'b0;
  logic         drv_oready = 1'b0;
  logic         rnd_or = 1'b0;

  int checks = 0;
  int errors = 0;

  operand_gather_if #(.WIDTH(W)) if0 ();
  operand_gather_if #(.WIDTH(W)) if1 ();

  assign if0.in_data   = drv_data;
  assign if0.in_valid  = drv_valid;
  assign if0.in_last   = drv_last;
  assign if0.out_ready = drv_oready;
  assign if1.in_data   = drv_data;
  assign if1.in_valid  = drv_valid;
  assign if1.in_last   = drv_last;
  assign if1.out_ready = drv_oready;

  operand_gather #(.WIDTH(W), .PAD_ONES(1'b1)) dut1 (.clk(clk), .resetn(resetn), .bus(if0));
  operand_gather #(.WIDTH(W), .PAD_ONES(1'b0)) dut0 (.clk(clk), .resetn(resetn), .bus(if1));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  // Behavioural model: the current group is a queue of accepted words.
  logic [W-1:0] grp [$];
  bit           mhold = 1'b0;
  bit           chk_en = 1'b0;
  int           groups_released = 0;

  initial forever begin
    @(posedge clk);
    if (!resetn) begin
      grp.delete();
      mhold  = 1'b0;
      chk_en = 1'b1;
    end else if (mhold) begin
      if (drv_oready) begin
        grp.delete();
        mhold = 1'b0;
        groups_released++;
      end
    end else if (drv_valid) begin
      grp.push_back(drv_data);
      if (grp.size() == 8 || drv_last) mhold = 1'b1;
    end
  end

  function automatic logic [W-1:0] exp_slot(int i, bit ones);
    if (i < grp.size()) return grp[i];
    return ones ? 7'h7F : 7'h00;
  endfunction

  initial forever begin
    logic [W-1:0] s0 [8];
    logic [W-1:0] s1 [8];
    @(negedge clk);
    if (chk_en) begin
      s0 = '{if0.a, if0.b, if0.c, if0.d, if0.e, if0.f, if0.g, if0.h};
      s1 = '{if1.a, if1.b, if1.c, if1.d, if1.e, if1.f, if1.g, if1.h};
      chk("in_ready", int'(if0.in_ready), int'(!mhold));
      chk("out_valid", int'(if0.out_valid), int'(mhold));
      chk("word_cnt", int'(if0.word_cnt), grp.size());
      chk("in_ready_p0", int'(if1.in_ready), int'(!mhold));
      chk("out_valid_p0", int'(if1.out_valid), int'(mhold));
      chk("word_cnt_p0", int'(if1.word_cnt), grp.size());
      for (int i = 0; i < 8; i++) begin
        chk($sformatf("slot%0d_pad1", i), int'(s0[i]), int'(exp_slot(i, 1'b1)));
        chk($sformatf("slot%0d_pad0", i), int'(s1[i]), int'(exp_slot(i, 1'b0)));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Present one word and hold it until it is accepted (bounded wait).
  task automatic send(input logic [W-1:0] w, input logic last);
    bit r;
    bit ok = 1'b0;
    drv_valid = 1'b1;
    drv_data  = w;
    drv_last  = last;
    for (int n = 0; n < 60; n++) begin
      if (rnd_or) drv_oready = 1'($urandom_range(0, 1));
      @(negedge clk);
      r = if0.in_ready;
      step();
      if (r) begin
        ok = 1'b1;
        break;
      end
    end
    drv_oready = rnd_or ? 1'b0 : drv_oready;
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic idle();
    drv_valid = 1'b0;
    drv_last  = 1'b0;
  endtask

  task automatic release_grp();
    drv_oready = 1'b1;
    step();
    drv_oready = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    resetn = 1'b0;
    step();
    resetn = 1'b1;
  endtask

  initial begin
    logic [W-1:0] full_v [8];
    full_v = '{7'h7F, 7'h7F, 7'h7E, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    repeat (2) @(posedge clk);
    #2;
    chk("rst_in_ready", int'(if0.in_ready), 1);
    chk("rst_word_cnt", int'(if0.word_cnt), 0);
    chk("rst_pad1_h", int'(if0.h), 'h7F);
    chk("rst_pad0_h", int'(if1.h), 'h00);
    resetn = 1'b1;

    // Full group, AND result 0x7E
    for (int i = 0; i < 8; i++) send(full_v[i], 1'b0);
    idle();
    chk("full_out_valid", int'(if0.out_valid), 1);
    chk("full_c", int'(if0.c), 'h7E);
    chk("full_word_cnt", int'(if0.word_cnt), 8);
    chk("full_and", int'(if0.a & if0.b & if0.c & if0.d & if0.e & if0.f & if0.g & if0.h), 'h7E);
    repeat (3) step();
    chk("full_hold_in_ready", int'(if0.in_ready), 0);
    release_grp();
    chk("full_rel_out_valid", int'(if0.out_valid), 0);
    chk("full_rel_in_ready", int'(if0.in_ready), 1);

    // Short group padded with the neutral value
    send(7'h15, 1'b0);
    send(7'h3C, 1'b1);
    idle();
    chk("short_a", int'(if0.a), 'h15);
    chk("short_b", int'(if0.b), 'h3C);
    chk("short_c_pad1", int'(if0.c), 'h7F);
    chk("short_h_pad0", int'(if1.h), 'h00);
    chk("short_cnt", int'(if0.word_cnt), 2);
    chk("short_valid", int'(if0.out_valid), 1);
    release_grp();

    // Backpressure: HOLD ignores in_valid, then no same-cycle pass-through
    for (int i = 0; i < 8; i++) send(7'(i + 1), 1'b0);
    for (int i = 0; i < 5; i++) begin
      drv_valid = 1'b1;
      drv_data  = 7'($urandom);
      step();
    end
    chk("bp_a_stable", int'(if0.a), 1);
    chk("bp_h_stable", int'(if0.h), 8);
    drv_data   = 7'h11;
    drv_oready = 1'b1;
    step();
    drv_oready = 1'b0;
    chk("bp_rel_cnt", int'(if0.word_cnt), 0);
    step();
    chk("bp_next_cnt", int'(if0.word_cnt), 1);
    chk("bp_next_a", int'(if0.a), 'h11);
    do_reset();

    // Single-word group
    send(7'h2A, 1'b1);
    idle();
    chk("single_a", int'(if0.a), 'h2A);
    chk("single_b", int'(if0.b), 'h7F);
    chk("single_cnt", int'(if0.word_cnt), 1);
    release_grp();

    // Reset mid-group
    for (int i = 0; i < 5; i++) send(7'(i + 7'h30), 1'b0);
    do_reset();
    chk("rmid_cnt", int'(if0.word_cnt), 0);
    chk("rmid_a_pad", int'(if0.a), 'h7F);
    chk("rmid_in_ready", int'(if0.in_ready), 1);
    for (int i = 0; i < 8; i++) send(7'(i + 7'h40), 1'b0);
    idle();
    chk("rmid_fresh_cnt", int'(if0.word_cnt), 8);
    chk("rmid_fresh_a", int'(if0.a), 'h40);
    release_grp();

    // Random soak: 10 groups with random gaps, lengths and release timing
    rnd_or = 1'b1;
    for (int g = 0; g < 10; g++) begin
      int k;
      k = $urandom_range(1, 8);
      for (int j = 0; j < k; j++) begin
        repeat ($urandom_range(0, 2)) begin
          drv_valid  = 1'b0;
          drv_data   = 7'($urandom);
          drv_last   = 1'($urandom);
          drv_oready = 1'($urandom_range(0, 1));
          step();
        end
        send(7'($urandom), (j == k - 1) ? ((k == 8) ? 1'($urandom) : 1'b1) : 1'b0);
      end
      idle();
    end
    rnd_or = 1'b0;
    release_grp();
    repeat (2) step();
    chk("soak_groups_min", int'(groups_released >= 14), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
